// File: rtl/p2s_tx_pkg.sv
// p2s_tx_pkg: shared state encodings, defaults and width helper for the serial transmitter
package p2s_tx_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_HALF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // ceil(log2(v)), never less than 1 so counters always have at least one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/p2s_tx_tick.sv
// p2s_tick: half-period divider, one-cycle tick every HALF enabled cycles, restartable by clear
module p2s_tick
    import p2s_tx_pkg::*;
#(
    parameter int HALF = DEF_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int DW = clog2(HALF);
    localparam logic [DW-1:0] TOP = DW'(HALF - 1);

    logic [DW-1:0] cnt;

    assign tick = en && (cnt == TOP);

    // divider counts only while enabled and wraps on its own tick
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + DW'(1);
    end

endmodule

// File: rtl/p2s_tx.sv
// p2s_tx: 32-bit parallel-to-serial transmitter with clock, data and latch outputs
module p2s_tx
    import p2s_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HALF  = DEF_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] par_data,
    output logic             busy,
    output logic             done,
    output logic             s_clk,
    output logic             s_data,
    output logic             s_latch
);

    localparam int BW = clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic             phase;
    logic             tick;
    logic             last_bit;

    assign last_bit = tick && phase && (bit_cnt == LAST);

    p2s_tick #(.HALF(HALF)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (state != ST_IDLE),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_n;
    end

    // next-state logic; unused encoding falls back to idle
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_n = last_bit ? ST_LATCH : ST_SHIFT;
            ST_LATCH: state_n = tick ? ST_IDLE : ST_LATCH;
            default:  state_n = ST_IDLE;
        endcase
    end

    // datapath and registered outputs; sreg holds the bits still to come after s_data
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_clk   <= 1'b0;
            s_data  <= 1'b0;
            s_latch <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg    <= par_data << 1;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                        busy    <= 1'b1;
                        s_clk   <= 1'b0;
                        s_data  <= par_data[WIDTH-1];
                        s_latch <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tick && !phase) begin
                        phase <= 1'b1;
                        s_clk <= 1'b1;
                    end else if (tick) begin
                        phase   <= 1'b0;
                        s_clk   <= 1'b0;
                        sreg    <= sreg << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        s_data  <= last_bit ? 1'b0 : sreg[WIDTH-1];
                        s_latch <= last_bit;
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        s_latch <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// tb_p2s_tx: directed self-checking bench for p2s_tx at default and HALF=1 settings
module tb_p2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] par_data = '0;
    logic        busy, done, s_clk, s_data, s_latch;

    logic        f_start = 1'b0;
    logic [31:0] f_par_data = '0;
    logic        f_busy, f_done, f_s_clk, f_s_data, f_s_latch;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] rx = '0;
    int          rises = 0, busy_cnt = 0, done_cnt = 0, n_acc = 0;
    logic        p_clk = 1'b0, p_busy = 1'b0;

    logic [31:0] f_rx = '0;
    int          f_rises = 0, f_busy_cnt = 0, f_tog = 0;
    logic        pf_clk = 1'b0;

    always #5 clk = ~clk;

    p2s_tx u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .par_data (par_data),
        .busy     (busy),
        .done     (done),
        .s_clk    (s_clk),
        .s_data   (s_data),
        .s_latch  (s_latch)
    );

    p2s_tx #(.WIDTH(32), .HALF(1)) u_fast (
        .clk      (clk),
        .rst      (rst),
        .start    (f_start),
        .par_data (f_par_data),
        .busy     (f_busy),
        .done     (f_done),
        .s_clk    (f_s_clk),
        .s_data   (f_s_data),
        .s_latch  (f_s_latch)
    );

    // receiver model: sample data on each serial clock rise, tally activity
    always @(negedge clk) begin
        p_clk  <= s_clk;
        p_busy <= busy;
        if (s_clk && !p_clk) begin
            rx    <= {rx[30:0], s_data};
            rises <= rises + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (busy && !p_busy) n_acc <= n_acc + 1;
    end

    // receiver model for the HALF=1 instance
    always @(negedge clk) begin
        pf_clk <= f_s_clk;
        if (f_s_clk && !pf_clk) begin
            f_rx    <= {f_rx[30:0], f_s_data};
            f_rises <= f_rises + 1;
        end
        if (f_busy) f_busy_cnt <= f_busy_cnt + 1;
        if (f_busy && f_s_clk != pf_clk) f_tog <= f_tog + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int lim);
        for (int i = 0; i < lim && !done; i++) tick_n();
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int k, m, r0, b0, a0, d0, t_last;
        logic pb;
        logic [31:0] exp_q[$];

        // reset state
        repeat (2) tick_n();
        check("rst_out", 32'({busy, done, s_clk, s_data, s_latch}), 32'd0);
        check("rst_fast", 32'({f_busy, f_done, f_s_clk, f_s_data, f_s_latch}), 32'd0);
        rst = 1'b0;
        tick_n();

        // basic transfer at defaults with exact timing
        r0 = rises;
        b0 = busy_cnt;
        start = 1'b1;
        par_data = 32'hA500_0001;
        tick_n();
        start = 1'b0;
        par_data = 32'hFFFF_0000;
        check("e1_busy", 32'(busy), 32'd1);
        check("e1_data", 32'(s_data), 32'd1);
        check("e1_clk", 32'(s_clk), 32'd0);
        k = 0;
        while (!s_clk && k < 50) begin tick_n(); k++; end
        check("rise0_at", k, 4);
        while (!s_latch && k < 600) begin tick_n(); k++; end
        check("latch_at", k, 256);
        m = 0;
        while (s_latch && m < 50) begin tick_n(); m++; end
        check("latch_len", m, 4);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        check("rx_a5", rx, 32'hA500_0001);
        check("rises_a5", rises - r0, 32);
        check("busy_len", busy_cnt - b0, 260);
        tick_n();
        check("done_1cyc", 32'(done), 32'd0);

        // HALF=1: all ones, clock toggles every cycle
        f_start = 1'b1;
        f_par_data = 32'hFFFF_FFFF;
        tick_n();
        f_start = 1'b0;
        f_par_data = '0;
        for (int i = 0; i < 200 && !f_done; i++) tick_n();
        check("f_done", 32'(f_done), 32'd1);
        check("f_rx", f_rx, 32'hFFFF_FFFF);
        check("f_rises", f_rises, 32);
        check("f_busy_len", f_busy_cnt, 65);
        check("f_toggles", f_tog, 64);

        // start held high, data changing every cycle
        r0 = rises;
        pb = busy;
        t_last = -1;
        start = 1'b1;
        par_data = 32'h3C00_0000;
        for (int i = 0; i < 800; i++) begin
            tick_n();
            if (done) begin
                check("hold_rx", rx, exp_q.pop_front());
                check("hold_rises", rises - r0, 32);
                r0 = rises;
            end
            if (busy && !pb) begin
                exp_q.push_back(par_data);
                if (t_last >= 0) check("hold_gap", i - t_last, 261);
                t_last = i;
            end
            pb = busy;
            par_data = 32'h3C00_0000 ^ (i * 32'h9E37_79B1);
        end
        start = 1'b0;
        par_data = '0;
        wait_done("hold_tail_done", 300);
        check("hold_tail_rx", rx, exp_q.pop_front());
        check("hold_tail_rises", rises - r0, 32);
        tick_n();

        // start during bit 10 is ignored
        start = 1'b1;
        par_data = 32'h5A5A_0F0F;
        tick_n();
        start = 1'b0;
        par_data = '0;
        r0 = rises;
        a0 = n_acc;
        for (int i = 0; i < 400 && rises - r0 < 10; i++) tick_n();
        start = 1'b1;
        par_data = 32'hFFFF_FFFF;
        tick_n();
        start = 1'b0;
        par_data = '0;
        wait_done("mid_done", 300);
        check("mid_rx", rx, 32'h5A5A_0F0F);
        check("mid_rises", rises - r0, 32);
        repeat (300) tick_n();
        check("mid_no_second", n_acc - a0, 0);

        // reset at cycle 100 of a transfer aborts it
        start = 1'b1;
        par_data = 32'hDEAD_BEEF;
        tick_n();
        start = 1'b0;
        repeat (98) tick_n();
        rst = 1'b1;
        tick_n();
        check("abort_out", 32'({busy, done, s_clk, s_data, s_latch}), 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (300) tick_n();
        check("abort_no_done", done_cnt - d0, 0);
        start = 1'b1;
        par_data = 32'h1234_5678;
        tick_n();
        start = 1'b0;
        par_data = '0;
        wait_done("post_rst_done", 300);
        check("post_rst_rx", rx, 32'h1234_5678);
        tick_n();

        // back-to-back acceptance on the done cycle
        start = 1'b1;
        par_data = 32'h0000_0000;
        tick_n();
        start = 1'b0;
        wait_done("b2b_done0", 300);
        check("b2b_rx0", rx, 32'h0000_0000);
        start = 1'b1;
        par_data = 32'h8000_0000;
        tick_n();
        start = 1'b0;
        par_data = '0;
        check("b2b_nogap", 32'(busy), 32'd1);
        wait_done("b2b_done1", 300);
        check("b2b_rx1", rx, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/p2s_tx.md
# p2s_tx

Parallel-to-serial transmitter that drains a 32-bit word, such as the value held by a CE-loaded pipeline or I/O register, onto a three-wire serial link: clock, data and latch. It drives the board's external LED and 7-segment shift-register chain. It accepts a word on a single-cycle `start`, shifts it out MSB-first with a programmable serial clock rate, pulses a latch, and reports completion.

## Interface
Parameters:
- `WIDTH`, default 32: word length in bits; must be ≥ 2.
- `HALF`, default 4: system-clock cycles per serial-clock half period; must be ≥ 1.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request to send `par_data`; sampled only in IDLE.
- `par_data`, input, `WIDTH`: word to transmit; captured on the accepting edge.
- `busy`, output, 1: high while in SHIFT or LATCH.
- `done`, output, 1: single-cycle pulse after the latch phase ends.
- `s_clk`, output, 1: serial clock; the receiver samples on its rising edge.
- `s_data`, output, 1: serial data, MSB first.
- `s_latch`, output, 1: high for `HALF` cycles after the last bit.

## Operation
- State machine: IDLE → SHIFT → LATCH → IDLE.
  - IDLE: if `start`=1 at an edge, load `par_data` into the shift register, clear the bit counter and divider, and go to SHIFT. Otherwise stay.
  - SHIFT: each bit occupies 2·`HALF` cycles.
    - Low phase: `HALF` cycles with `s_clk`=0 and `s_data` = current MSB of the shift register.
    - High phase: `HALF` cycles with `s_clk`=1 and `s_data` held.
    - At the end of the high phase, shift left by 1 and increment the bit counter.
    - After bit `WIDTH`−1 completes, go to LATCH.
  - LATCH: `s_clk`=0, `s_data`=0, `s_latch`=1 for `HALF` cycles. Then go to IDLE and assert `done` for exactly that first IDLE cycle.
- `start` while busy is ignored; no queuing.
- `start` in the cycle `done` is high is accepted, because the FSM is in IDLE.
- `par_data` changes after acceptance have no effect on the word being sent.
- Reset values, reached on the first edge with `rst`=1 and taking priority over everything:
  - state = IDLE
  - `busy`=0, `done`=0, `s_clk`=0, `s_data`=0, `s_latch`=0
  - shift register, bit counter and divider all cleared.
- Reset mid-SHIFT or mid-LATCH aborts the transfer silently. No `done` is issued.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Accepting edge is E0. From E0+1 the following hold:
  - `busy`=1
  - `s_data` = `par_data`[`WIDTH`−1]
  - `s_clk`=0
- First `s_clk` rise: E0+1+`HALF`.
- Bit k's `s_clk` rises at E0+1+(2k+1)·`HALF`.
- `s_latch` rises at E0+1+2·`WIDTH`·`HALF` and stays high for `HALF` cycles.
- `busy` is high for exactly (2·`WIDTH`+1)·`HALF` cycles. At the defaults this is 260 cycles.
- `done` is high in the first cycle `busy` is low.
- Earliest back-to-back acceptance is on the `done` cycle. The transfer-to-transfer period is (2·`WIDTH`+1)·`HALF`+1 cycles.
- Divider width is clog2(`HALF`), minimum 1. Bit-counter width is clog2(`WIDTH`). Both wrap only under FSM control, never free-running.

## Structure
- Shared header/package holds:
  - state encodings `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_LATCH`=2'd2
  - default `WIDTH`/`HALF`
  - the clog2 helper function
- One natural sub-module is `p2s_tick`. It is a half-period divider with a `clear` input and a one-cycle `tick` output every `HALF` cycles while enabled.
- The top level holds the FSM, shift register, bit counter, phase bit and output registers.

## Test plan
- Defaults, `par_data`=32'hA500_0001, one `start` pulse:
  - The bench captures `s_data` on each `s_clk` rise and gets 32'hA500_0001, MSB first.
  - `s_latch` is high for 4 cycles.
  - `busy` is high for 260 cycles, then `done` is high for 1 cycle.
- `WIDTH`=32, `HALF`=1, `par_data`=32'hFFFF_FFFF:
  - 32 rises, all with `s_data`=1.
  - `s_clk` toggles every cycle.
  - `busy` is high for 65 cycles.
- `start` held high continuously with data changing every cycle:
  - Each transfer carries the word present on its accepting edge.
  - Acceptances are spaced 261 cycles apart.
  - No extra `s_clk` rises inside a transfer.
- `start` pulsed at bit 10 of an active transfer:
  - Ignored; the transfer completes unchanged.
  - No second transfer follows.
- `rst` asserted at cycle 100 of a transfer:
  - Next cycle all outputs are 0 and the FSM is idle.
  - `done` never pulses.
  - A subsequent `start` with 32'h1234_5678 transmits correctly.
- `start` on the `done` cycle with 32'h0000_0000 then 32'h8000_0000:
  - Both words are received correctly.
  - No gap cycle between `done` and the second acceptance.
